// File: rtl/me_msad_tracker.sv
// Minimum-SAD tracker: consumes one row of candidate SADs per handshake and reports
// the global minimum with its column/row, optionally stopping early on a threshold.
module me_msad_tracker #(
  parameter int unsigned CAND_PER_ROW  = 16,
  parameter int unsigned NUM_ROWS      = 16,
  parameter int unsigned SAD_BIT_WIDTH = 14,
  parameter int unsigned COL_BITS      = 5,
  parameter int unsigned ROW_BITS      = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic                                  early_term_en_i,
  input  logic [SAD_BIT_WIDTH-1:0]              threshold_i,
  input  logic                                  batch_valid_i,
  output logic                                  batch_ready_o,
  input  logic [CAND_PER_ROW*SAD_BIT_WIDTH-1:0] sad_batch_i,
  output logic                                  result_valid_o,
  input  logic                                  result_ready_i,
  output logic [SAD_BIT_WIDTH-1:0]              msad_o,
  output logic [COL_BITS-1:0]                   msad_col_o,
  output logic [ROW_BITS-1:0]                   msad_row_o,
  output logic                                  early_term_o,
  output logic                                  busy_o
);

  localparam int unsigned W     = SAD_BIT_WIDTH;
  localparam int unsigned CNT_W = $clog2(NUM_ROWS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FLUSH} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]    row_cnt;
  logic                first;
  logic                en_q;
  logic [W-1:0]        thr_q;

  logic                s1_valid, s1_last;
  logic [W-1:0]        s1_min;
  logic [COL_BITS-1:0] s1_col;
  logic [ROW_BITS-1:0] s1_row;

  logic                s2_valid, s2_last, s2_hit;

  logic [W-1:0]        run_min;
  logic [COL_BITS-1:0] run_col;
  logic [ROW_BITS-1:0] run_row;

  logic                accept_c, start_c, last_acc_c, load_c, hit_c;
  logic [CNT_W-1:0]    cnt_next_c;
  logic [W-1:0]        row_min_c;
  logic [COL_BITS-1:0] row_col_c;

  assign accept_c   = batch_valid_i & batch_ready_o;
  assign start_c    = (state == IDLE) & start_i & ~result_valid_o;
  assign cnt_next_c = row_cnt + CNT_W'(accept_c);
  assign last_acc_c = (state == ACCUM) & accept_c & (row_cnt == CNT_W'(NUM_ROWS - 1));
  assign load_c     = s1_valid & (first | (s1_min < run_min));
  assign hit_c      = load_c & en_q & (s1_min <= thr_q);

  // Row minimum; strict compare keeps the lowest column on ties.
  always_comb begin
    row_min_c = sad_batch_i[W-1:0];
    row_col_c = '0;
    for (int unsigned c = 1; c < CAND_PER_ROW; c++) begin
      if (sad_batch_i[c*W +: W] < row_min_c) begin
        row_min_c = sad_batch_i[c*W +: W];
        row_col_c = COL_BITS'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_c) state_next = ACCUM;
      end
      ACCUM: begin
        if (hit_c) begin
          state_next = (cnt_next_c == CNT_W'(NUM_ROWS)) ? FLUSH : DRAIN;
        end else if (last_acc_c) begin
          state_next = FLUSH;
        end
      end
      DRAIN: begin
        if (accept_c && (cnt_next_c == CNT_W'(NUM_ROWS))) state_next = IDLE;
      end
      FLUSH: begin
        if (!s1_valid && !s2_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      batch_ready_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      batch_ready_o <= (state_next == ACCUM) || (state_next == DRAIN);
      busy_o        <= (state_next != IDLE);
    end
  end

  // Counters, two-stage min pipeline and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt        <= '0;
      first          <= 1'b0;
      en_q           <= 1'b0;
      thr_q          <= '0;
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      s1_min         <= '0;
      s1_col         <= '0;
      s1_row         <= '0;
      s2_valid       <= 1'b0;
      s2_last        <= 1'b0;
      s2_hit         <= 1'b0;
      run_min        <= '0;
      run_col        <= '0;
      run_row        <= '0;
      result_valid_o <= 1'b0;
      msad_o         <= '0;
      msad_col_o     <= '0;
      msad_row_o     <= '0;
      early_term_o   <= 1'b0;
    end else begin
      if (start_c) begin
        row_cnt <= '0;
        first   <= 1'b1;
        en_q    <= early_term_en_i;
        thr_q   <= threshold_i;
      end else if (accept_c) begin
        row_cnt <= cnt_next_c;
      end

      // A termination hit discards whatever row is being accepted on the same edge.
      s1_valid <= (state == ACCUM) & accept_c & ~hit_c;
      if (accept_c) begin
        s1_min  <= row_min_c;
        s1_col  <= row_col_c;
        s1_row  <= ROW_BITS'(row_cnt);
        s1_last <= last_acc_c;
      end

      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;
      s2_hit   <= hit_c;

      if (load_c) begin
        run_min <= s1_min;
        run_col <= s1_col;
        run_row <= s1_row;
        first   <= 1'b0;
      end

      if (result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
        msad_o         <= '0;
        msad_col_o     <= '0;
        msad_row_o     <= '0;
        early_term_o   <= 1'b0;
      end
      if (s2_valid && (s2_last || s2_hit)) begin
        result_valid_o <= 1'b1;
        msad_o         <= run_min;
        msad_col_o     <= run_col;
        msad_row_o     <= run_row;
        early_term_o   <= s2_hit;
      end
    end
  end

endmodule

// File: tb/tb_me_msad_tracker.sv
// Scoreboard bench for me_msad_tracker: default instance plus an 8x33 parameter variant.
module tb_me_msad_tracker;

  localparam int unsigned W = 14;

  typedef struct packed {
    logic [W-1:0] msad;
    logic [4:0]   col;
    logic [4:0]   row;
    logic         et;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start_i, early_term_en_i, batch_valid_i, batch_ready_o;
  logic [W-1:0]   threshold_i;
  logic [16*W-1:0] sad_batch_i;
  logic           result_valid_o, result_ready_i, early_term_o, busy_o;
  logic [W-1:0]   msad_o;
  logic [4:0]     msad_col_o, msad_row_o;

  me_msad_tracker dut (
    .clk(clk), .rst(rst), .start_i(start_i), .early_term_en_i(early_term_en_i),
    .threshold_i(threshold_i), .batch_valid_i(batch_valid_i), .batch_ready_o(batch_ready_o),
    .sad_batch_i(sad_batch_i), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .msad_o(msad_o), .msad_col_o(msad_col_o), .msad_row_o(msad_row_o),
    .early_term_o(early_term_o), .busy_o(busy_o)
  );

  logic           p_start, p_bvalid, p_bready, p_rvalid, p_et, p_busy;
  logic [8*W-1:0] p_batch;
  logic [W-1:0]   p_msad;
  logic [2:0]     p_col;
  logic [5:0]     p_row;

  me_msad_tracker #(.CAND_PER_ROW(8), .NUM_ROWS(33), .SAD_BIT_WIDTH(14), .COL_BITS(3), .ROW_BITS(6)) dut_p (
    .clk(clk), .rst(rst), .start_i(p_start), .early_term_en_i(1'b0),
    .threshold_i(14'd0), .batch_valid_i(p_bvalid), .batch_ready_o(p_bready),
    .sad_batch_i(p_batch), .result_valid_o(p_rvalid), .result_ready_i(1'b1),
    .msad_o(p_msad), .msad_col_o(p_col), .msad_row_o(p_row),
    .early_term_o(p_et), .busy_o(p_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc, acc_cyc;
  logic prev_valid = 1'b0;
  res_t sb[$];
  logic [W-1:0] sads [16][16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: timestamps result rise and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    #1;
    if (result_valid_o && !prev_valid) rise_cyc = cyc;
    prev_valid = result_valid_o;
    if (result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'(1), 32'(0));
      end else begin
        res_t e;
        e = sb.pop_front();
        check("msad", 32'(msad_o), 32'(e.msad));
        check("col", 32'(msad_col_o), 32'(e.col));
        check("row", 32'(msad_row_o), 32'(e.row));
        check("early_term", 32'(early_term_o), 32'(e.et));
      end
    end
  end

  function automatic logic [16*W-1:0] pack_row(input int r);
    logic [16*W-1:0] v;
    for (int c = 0; c < 16; c++) v[c*W +: W] = sads[r][c];
    return v;
  endfunction

  // Reference: earliest row wins ties, termination only on a newly loaded minimum.
  task automatic model(input bit en, input logic [W-1:0] thr, output res_t res, output int res_row);
    bit first = 1'b1;
    res = '0;
    res_row = 15;
    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] m;
      int mc;
      m = sads[r][0];
      mc = 0;
      for (int c = 1; c < 16; c++) if (sads[r][c] < m) begin m = sads[r][c]; mc = c; end
      if (first || m < res.msad) begin
        first = 1'b0;
        res.msad = m;
        res.col = 5'(mc);
        res.row = 5'(r);
        if (en && m <= thr) begin
          res.et = 1'b1;
          res_row = r;
          return;
        end
      end
    end
  endtask

  task automatic fill(input logic [W-1:0] v);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) sads[r][c] = v;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o || result_valid_o) && n < 300) begin @(negedge clk); n++; end
    check(tag, 32'(busy_o | result_valid_o), 32'(0));
  endtask

  task automatic start_search(input bit en, input logic [W-1:0] thr);
    early_term_en_i = en;
    threshold_i = thr;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_search(input string tag, input bit en, input logic [W-1:0] thr,
                            input bit gap, input bit hold);
    res_t exp;
    int res_row, r, waits, n;
    bit tog;
    model(en, thr, exp, res_row);
    wait_idle({tag, "_idle"});
    result_ready_i = !hold;
    rise_cyc = -100;
    acc_cyc = 0;
    sb.push_back(exp);
    start_search(en, thr);
    r = 0; waits = 0; n = 0; tog = 1'b0;
    while (r < 16 && n < 500) begin
      tog = ~tog;
      batch_valid_i = gap ? tog : 1'b1;
      sad_batch_i = pack_row(r);
      if (batch_valid_i && batch_ready_o) begin
        if (r == res_row) acc_cyc = cyc + 1;
        r++;
      end else if (batch_valid_i) begin
        waits++;
      end
      @(negedge clk);
      n++;
    end
    batch_valid_i = 1'b0;
    check({tag, "_rows_accepted"}, 32'(r), 32'(16));
    if (exp.et) begin
      check({tag, "_drain_no_stall"}, 32'(waits), 32'(0));
      check({tag, "_busy_after_last"}, 32'(busy_o), 32'(0));
    end
    if (hold) begin
      n = 0;
      while (!result_valid_o && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
        check({tag, "_hold_valid"}, 32'(result_valid_o), 32'(1));
        check({tag, "_hold_msad"}, 32'(msad_o), 32'(exp.msad));
        start_i = (i == 3);
        @(negedge clk);
      end
      check({tag, "_start_ignored"}, 32'(busy_o), 32'(0));
      result_ready_i = 1'b1;
    end
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
    check({tag, "_latency"}, 32'(rise_cyc - acc_cyc), 32'(2));
  endtask

  task automatic run_param;
    int r = 0, n = 0;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    while (r < 33 && n < 300) begin
      p_bvalid = 1'b1;
      for (int c = 0; c < 8; c++) p_batch[c*W +: W] = (r == 32 && c == 7) ? 14'd2 : 14'(1000 + r*8 + c);
      if (p_bready) r++;
      @(negedge clk);
      n++;
    end
    p_bvalid = 1'b0;
    n = 0;
    while (!p_rvalid && n < 20) begin @(negedge clk); n++; end
    check("p_valid", 32'(p_rvalid), 32'(1));
    check("p_msad", 32'(p_msad), 32'(2));
    check("p_col", 32'(p_col), 32'(7));
    check("p_row", 32'(p_row), 32'(32));
    check("p_early_term", 32'(p_et), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; early_term_en_i = 1'b0; threshold_i = '0;
    batch_valid_i = 1'b0; sad_batch_i = '0; result_ready_i = 1'b1;
    p_start = 1'b0; p_bvalid = 1'b0; p_batch = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(result_valid_o), 32'(0));
    check("rst_ready", 32'(batch_ready_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_msad", 32'(msad_o), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) sads[r][c] = 14'(1000 + r*16 + c);
    sads[5][9] = 14'd3;
    run_search("t1_basic", 1'b0, 14'd0, 1'b0, 1'b0);

    fill(14'd77);
    run_search("t2_all_equal", 1'b0, 14'd0, 1'b0, 1'b0);

    fill(14'd500);
    sads[2][4] = 14'd5;
    sads[2][11] = 14'd5;
    run_search("t2_col_tie", 1'b0, 14'd0, 1'b0, 1'b0);

    fill(14'd900);
    sads[3][1] = 14'd8;
    run_search("t3_early_term", 1'b1, 14'd10, 1'b0, 1'b0);

    fill(14'h3fff);
    run_search("all_ones", 1'b0, 14'd0, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) sads[r][c] = 14'($urandom_range(50, 16000));
    run_search("t4_backpressure", 1'b0, 14'd0, 1'b1, 1'b1);

    // Abort a search of zero SADs after 7 rows, then a clean search must ignore them.
    wait_idle("t5_idle");
    start_search(1'b0, 14'd0);
    batch_valid_i = 1'b1;
    sad_batch_i = '0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    rst = 1'b1;
    batch_valid_i = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", 32'(result_valid_o), 32'(0));
    check("t5_rst_ready", 32'(batch_ready_o), 32'(0));
    check("t5_rst_busy", 32'(busy_o), 32'(0));
    check("t5_rst_outs", 32'({msad_o, msad_col_o, msad_row_o, early_term_o}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) sads[r][c] = 14'(2000 + ((r*7 + c*3) % 41));
    sads[11][14] = 14'd1500;
    run_search("t5_after_abort", 1'b0, 14'd0, 1'b0, 1'b0);

    run_param();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
